// File: rtl/cfg_sched_if.sv
// Step/configuration bundle between the layer config FIFO, cfg_sched and the compute array.
// master: the scheduler (consumes cfg fields, drives steps); slave: FIFO + compute array side.
interface cfg_sched_if #(
  parameter int unsigned LenRowW = 4,
  parameter int unsigned BlkW    = 6,
  parameter int unsigned FrameW  = 5,
  parameter int unsigned PatchW  = 6,
  parameter int unsigned FtrGrpW = 4,
  parameter int unsigned LayerW  = 5,
  parameter int unsigned PoolW   = 4
);
  // Configuration FIFO output
  logic               cfg_val;
  logic [5:0]         cfg_loop_pty;
  logic [LenRowW-1:0] cfg_len_row;
  logic [BlkW-1:0]    cfg_dep_blk;
  logic [BlkW-1:0]    cfg_num_blk;
  logic [FrameW-1:0]  cfg_num_frm;
  logic [PatchW-1:0]  cfg_num_pat;
  logic [FtrGrpW-1:0] cfg_num_ftr_grp;
  logic [LayerW-1:0]  cfg_num_lay;
  logic [PoolW-1:0]   cfg_pool;

  // Step stream to the compute array
  logic               sched_rdy;
  logic               sched_val;
  logic [FrameW-1:0]  sched_frm;
  logic [PatchW-1:0]  sched_pat;
  logic [FtrGrpW-1:0] sched_ftr_grp;
  logic [BlkW-1:0]    sched_blk;
  logic               sched_last;
  logic [LenRowW-1:0] sched_len_row;
  logic [BlkW-1:0]    sched_dep_blk;
  logic [PoolW-1:0]   sched_pool;

  modport master (
    input  cfg_val, cfg_loop_pty, cfg_len_row, cfg_dep_blk, cfg_num_blk, cfg_num_frm,
           cfg_num_pat, cfg_num_ftr_grp, cfg_num_lay, cfg_pool, sched_rdy,
    output sched_val, sched_frm, sched_pat, sched_ftr_grp, sched_blk, sched_last,
           sched_len_row, sched_dep_blk, sched_pool
  );

  modport slave (
    output cfg_val, cfg_loop_pty, cfg_len_row, cfg_dep_blk, cfg_num_blk, cfg_num_frm,
           cfg_num_pat, cfg_num_ftr_grp, cfg_num_lay, cfg_pool, sched_rdy,
    input  sched_val, sched_frm, sched_pat, sched_ftr_grp, sched_blk, sched_last,
           sched_len_row, sched_dep_blk, sched_pool
  );
endinterface

// File: rtl/cfg_sched.sv
// Layer loop scheduler: walks frame/patch/ftrgrp/blk per layer in the configured loop order,
// emits one step per accepted handshake, pops the config FIFO after each layer.
module cfg_sched #(
  parameter int unsigned LenRowW = 4,
  parameter int unsigned BlkW    = 6,
  parameter int unsigned FrameW  = 5,
  parameter int unsigned PatchW  = 6,
  parameter int unsigned FtrGrpW = 4,
  parameter int unsigned LayerW  = 5,
  parameter int unsigned PoolW   = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              net_start_i,
  cfg_sched_if.master       sched_if,
  output logic [LayerW-1:0] layer_idx_o,
  output logic              rst_layer_o,
  output logic              net_done_o,
  output logic              busy_o
);

  typedef enum logic [2:0] {StIdle, StWait, StLoad, StRun, StDone, StSettle} state_e;

  // Loop ids as carried in the loop-priority field
  localparam logic [1:0] IdPat = 2'd0;
  localparam logic [1:0] IdFtr = 2'd1;
  localparam logic [1:0] IdBlk = 2'd2;

  state_e             state_q, state_d;
  logic [LayerW-1:0]  layer_idx_q, layer_idx_d;
  logic [LayerW-1:0]  num_lay_q, num_lay_d;
  logic [FrameW-1:0]  num_frm_q, num_frm_d, frm_q, frm_d;
  logic [PatchW-1:0]  num_pat_q, num_pat_d, pat_q, pat_d;
  logic [FtrGrpW-1:0] num_ftr_q, num_ftr_d, ftr_q, ftr_d;
  logic [BlkW-1:0]    num_blk_q, num_blk_d, blk_q, blk_d;
  logic [LenRowW-1:0] len_row_q, len_row_d;
  logic [BlkW-1:0]    dep_blk_q, dep_blk_d;
  logic [PoolW-1:0]   pool_q, pool_d;
  logic [1:0]         outer_q, outer_d, mid_q, mid_d, inner_q, inner_d;

  logic [1:0] pty_outer, pty_mid, pty_inner;
  logic       pty_ok;
  logic [3:0] wrap, inc;
  logic       frm_inc, all_wrap, run, accept;

  // Loop-order decode with fallback to patch/ftrgrp/blk for non-permutations
  always_comb begin
    pty_outer = sched_if.cfg_loop_pty[5:4];
    pty_mid   = sched_if.cfg_loop_pty[3:2];
    pty_inner = sched_if.cfg_loop_pty[1:0];
    pty_ok    = (pty_outer != 2'd3) && (pty_mid != 2'd3) && (pty_inner != 2'd3) &&
                (pty_outer != pty_mid) && (pty_outer != pty_inner) && (pty_mid != pty_inner);
    if (!pty_ok) begin
      pty_outer = IdPat;
      pty_mid   = IdFtr;
      pty_inner = IdBlk;
    end
  end

  // Per-loop wrap flags and carry chain routed through the latched loop order
  always_comb begin
    wrap           = 4'b0000;
    wrap[IdPat]    = (pat_q == num_pat_q);
    wrap[IdFtr]    = (ftr_q == num_ftr_q);
    wrap[IdBlk]    = (blk_q == num_blk_q);
    all_wrap       = wrap[IdPat] & wrap[IdFtr] & wrap[IdBlk];
    inc            = 4'b0000;
    inc[inner_q]   = 1'b1;
    inc[mid_q]     = wrap[inner_q];
    inc[outer_q]   = wrap[inner_q] & wrap[mid_q];
    frm_inc        = all_wrap;
  end

  assign run    = (state_q == StRun);
  assign accept = run && sched_if.sched_rdy;

  // Next-state, index advance and parameter latching
  always_comb begin
    state_d     = state_q;
    layer_idx_d = layer_idx_q;
    num_lay_d   = num_lay_q;
    num_frm_d   = num_frm_q;
    num_pat_d   = num_pat_q;
    num_ftr_d   = num_ftr_q;
    num_blk_d   = num_blk_q;
    frm_d       = frm_q;
    pat_d       = pat_q;
    ftr_d       = ftr_q;
    blk_d       = blk_q;
    len_row_d   = len_row_q;
    dep_blk_d   = dep_blk_q;
    pool_d      = pool_q;
    outer_d     = outer_q;
    mid_d       = mid_q;
    inner_d     = inner_q;

    unique case (state_q)
      StIdle: begin
        if (net_start_i) begin
          state_d     = StWait;
          layer_idx_d = '0;
        end
      end
      StWait: begin
        if (sched_if.cfg_val) state_d = StLoad;
      end
      StLoad: begin
        num_frm_d = sched_if.cfg_num_frm;
        num_pat_d = sched_if.cfg_num_pat;
        num_ftr_d = sched_if.cfg_num_ftr_grp;
        num_blk_d = sched_if.cfg_num_blk;
        len_row_d = sched_if.cfg_len_row;
        dep_blk_d = sched_if.cfg_dep_blk;
        pool_d    = sched_if.cfg_pool;
        // Network length comes from the first layer's word only
        if (layer_idx_q == '0) num_lay_d = sched_if.cfg_num_lay;
        frm_d     = '0;
        pat_d     = '0;
        ftr_d     = '0;
        blk_d     = '0;
        outer_d   = pty_outer;
        mid_d     = pty_mid;
        inner_d   = pty_inner;
        state_d   = StRun;
      end
      StRun: begin
        if (accept) begin
          if (inc[IdPat]) pat_d = wrap[IdPat] ? '0 : pat_q + 1'b1;
          if (inc[IdFtr]) ftr_d = wrap[IdFtr] ? '0 : ftr_q + 1'b1;
          if (inc[IdBlk]) blk_d = wrap[IdBlk] ? '0 : blk_q + 1'b1;
          if (frm_inc)    frm_d = (frm_q == num_frm_q) ? '0 : frm_q + 1'b1;
          if (all_wrap && (frm_q == num_frm_q)) state_d = StDone;
        end
      end
      StDone: begin
        if (layer_idx_q == num_lay_q) begin
          state_d = StIdle;
        end else begin
          layer_idx_d = layer_idx_q + 1'b1;
          state_d     = StSettle;
        end
      end
      StSettle: begin
        // FIFO output is still updating after the pop; cfg_val not trusted yet
        state_d = StWait;
      end
      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      layer_idx_q <= '0;
      num_lay_q   <= '0;
      num_frm_q   <= '0;
      num_pat_q   <= '0;
      num_ftr_q   <= '0;
      num_blk_q   <= '0;
      frm_q       <= '0;
      pat_q       <= '0;
      ftr_q       <= '0;
      blk_q       <= '0;
      len_row_q   <= '0;
      dep_blk_q   <= '0;
      pool_q      <= '0;
      outer_q     <= IdPat;
      mid_q       <= IdFtr;
      inner_q     <= IdBlk;
    end else begin
      state_q     <= state_d;
      layer_idx_q <= layer_idx_d;
      num_lay_q   <= num_lay_d;
      num_frm_q   <= num_frm_d;
      num_pat_q   <= num_pat_d;
      num_ftr_q   <= num_ftr_d;
      num_blk_q   <= num_blk_d;
      frm_q       <= frm_d;
      pat_q       <= pat_d;
      ftr_q       <= ftr_d;
      blk_q       <= blk_d;
      len_row_q   <= len_row_d;
      dep_blk_q   <= dep_blk_d;
      pool_q      <= pool_d;
      outer_q     <= outer_d;
      mid_q       <= mid_d;
      inner_q     <= inner_d;
    end
  end

  // Outputs decoded from registered state only
  always_comb begin
    sched_if.sched_val     = run;
    sched_if.sched_frm     = frm_q;
    sched_if.sched_pat     = pat_q;
    sched_if.sched_ftr_grp = ftr_q;
    sched_if.sched_blk     = blk_q;
    sched_if.sched_last    = run && all_wrap && (frm_q == num_frm_q);
    sched_if.sched_len_row = len_row_q;
    sched_if.sched_dep_blk = dep_blk_q;
    sched_if.sched_pool    = pool_q;
    layer_idx_o            = layer_idx_q;
    rst_layer_o            = (state_q == StDone);
    net_done_o             = (state_q == StDone) && (layer_idx_q == num_lay_q);
    busy_o                 = (state_q != StIdle);
  end

endmodule

// File: tb/tb_cfg_sched.sv
// Bench for cfg_sched: directed layer runs with random shapes/backpressure against a
// mixed-radix model of the loop nest.
module tb_cfg_sched;
  localparam int unsigned LenRowW = 4;
  localparam int unsigned BlkW    = 6;
  localparam int unsigned FrameW  = 5;
  localparam int unsigned PatchW  = 6;
  localparam int unsigned FtrGrpW = 4;
  localparam int unsigned LayerW  = 5;
  localparam int unsigned PoolW   = 4;

  typedef struct {
    int frm, pat, fg, blk, lay, len, dep, pool;
    logic [5:0] pty;
  } cfg_t;

  logic clk = 1'b0;
  logic rst;
  logic net_start;
  logic [LayerW-1:0] layer_idx;
  logic rst_layer, net_done, busy;

  int errors = 0;
  int checks = 0;
  cfg_t cfgq[$];
  int   cq_ptr;
  logic [5:0] perms [6] = '{6'b00_01_10, 6'b00_10_01, 6'b01_00_10,
                            6'b01_10_00, 6'b10_00_01, 6'b10_01_00};

  cfg_sched_if #(.LenRowW(LenRowW), .BlkW(BlkW), .FrameW(FrameW), .PatchW(PatchW),
                 .FtrGrpW(FtrGrpW), .LayerW(LayerW), .PoolW(PoolW)) sif ();

  cfg_sched #(.LenRowW(LenRowW), .BlkW(BlkW), .FrameW(FrameW), .PatchW(PatchW),
              .FtrGrpW(FtrGrpW), .LayerW(LayerW), .PoolW(PoolW)) dut (
    .clk        (clk),
    .rst        (rst),
    .net_start_i(net_start),
    .sched_if   (sif.master),
    .layer_idx_o(layer_idx),
    .rst_layer_o(rst_layer),
    .net_done_o (net_done),
    .busy_o     (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Expected indices of step k: the ordered loops form a mixed-radix number, frame on top
  function automatic void exp_idx(input cfg_t c, input int k,
                                  output int f, output int p, output int g, output int b);
    int cnt[3];
    int e[3];
    int o, m, i;
    cnt[0] = c.pat + 1; cnt[1] = c.fg + 1; cnt[2] = c.blk + 1;
    o = int'(c.pty[5:4]); m = int'(c.pty[3:2]); i = int'(c.pty[1:0]);
    if (o > 2 || m > 2 || i > 2 || o == m || o == i || m == i) begin
      o = 0; m = 1; i = 2;
    end
    e[i] = k % cnt[i];
    e[m] = (k / cnt[i]) % cnt[m];
    e[o] = (k / (cnt[i] * cnt[m])) % cnt[o];
    f = k / (cnt[0] * cnt[1] * cnt[2]);
    p = e[0]; g = e[1]; b = e[2];
  endfunction

  function automatic cfg_t rand_cfg();
    cfg_t c;
    c.frm  = int'($urandom_range(0, 2));
    c.pat  = int'($urandom_range(0, 3));
    c.fg   = int'($urandom_range(0, 2));
    c.blk  = int'($urandom_range(0, 3));
    c.lay  = 0;
    c.len  = int'($urandom_range(0, 15));
    c.dep  = int'($urandom_range(0, 63));
    c.pool = int'($urandom_range(0, 15));
    c.pty  = perms[$urandom_range(0, 5)];
    return c;
  endfunction

  // FIFO model output: head of cfgq, or empty
  task automatic present_cfg();
    if (cq_ptr < cfgq.size()) begin
      sif.cfg_val         = 1'b1;
      sif.cfg_loop_pty    = cfgq[cq_ptr].pty;
      sif.cfg_num_frm     = FrameW'(cfgq[cq_ptr].frm);
      sif.cfg_num_pat     = PatchW'(cfgq[cq_ptr].pat);
      sif.cfg_num_ftr_grp = FtrGrpW'(cfgq[cq_ptr].fg);
      sif.cfg_num_blk     = BlkW'(cfgq[cq_ptr].blk);
      sif.cfg_num_lay     = LayerW'(cfgq[cq_ptr].lay);
      sif.cfg_len_row     = LenRowW'(cfgq[cq_ptr].len);
      sif.cfg_dep_blk     = BlkW'(cfgq[cq_ptr].dep);
      sif.cfg_pool        = PoolW'(cfgq[cq_ptr].pool);
    end else begin
      sif.cfg_val = 1'b0;
    end
  endtask

  task automatic scramble_cfg();
    sif.cfg_loop_pty    = 6'($urandom);
    sif.cfg_num_frm     = FrameW'($urandom);
    sif.cfg_num_pat     = PatchW'($urandom);
    sif.cfg_num_ftr_grp = FtrGrpW'($urandom);
    sif.cfg_num_blk     = BlkW'($urandom);
    sif.cfg_num_lay     = LayerW'($urandom);
    sif.cfg_len_row     = LenRowW'($urandom);
    sif.cfg_dep_blk     = BlkW'($urandom);
    sif.cfg_pool        = PoolW'($urandom);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_val"}, 32'(sif.sched_val), 0);
    check({tag, "_last"}, 32'(sif.sched_last), 0);
    check({tag, "_frm"}, 32'(sif.sched_frm), 0);
    check({tag, "_pat"}, 32'(sif.sched_pat), 0);
    check({tag, "_fg"}, 32'(sif.sched_ftr_grp), 0);
    check({tag, "_blk"}, 32'(sif.sched_blk), 0);
    check({tag, "_lenrow"}, 32'(sif.sched_len_row), 0);
    check({tag, "_depblk"}, 32'(sif.sched_dep_blk), 0);
    check({tag, "_pool"}, 32'(sif.sched_pool), 0);
    check({tag, "_layidx"}, 32'(layer_idx), 0);
    check({tag, "_rstlay"}, 32'(rst_layer), 0);
    check({tag, "_netdone"}, 32'(net_done), 0);
    check({tag, "_busy"}, 32'(busy), 0);
  endtask

  task automatic start_net();
    net_start = 1'b1;
    @(posedge clk); #1;
    net_start = 1'b0;
    check("start_busy", 32'(busy), 1);
    check("start_no_val", 32'(sif.sched_val), 0);
  endtask

  // Runs one layer from the sample point before its first step; abort_at>=0 returns early
  // with step abort_at on the bus.
  task automatic run_layer(input cfg_t c, input int lay, input bit is_last, input bit bp,
                           input int lat, input bit poke_start, input int abort_at);
    int total, k, cyc, waited, f, p, g, b;
    total  = (c.frm + 1) * (c.pat + 1) * (c.fg + 1) * (c.blk + 1);
    waited = 0;
    while (!sif.sched_val && waited < lat + 2) begin
      @(posedge clk); #1;
      waited++;
    end
    check("first_val_latency", 32'(waited), 32'(lat));
    if (!sif.sched_val) return;
    check("lenrow", 32'(sif.sched_len_row), 32'(c.len));
    check("depblk", 32'(sif.sched_dep_blk), 32'(c.dep));
    check("pool", 32'(sif.sched_pool), 32'(c.pool));
    scramble_cfg();
    k = 0;
    cyc = 0;
    while (k < total && cyc < total * 8 + 50) begin
      if (k == abort_at) return;
      exp_idx(c, k, f, p, g, b);
      check("step_val", 32'(sif.sched_val), 1);
      check("step_frm", 32'(sif.sched_frm), 32'(f));
      check("step_pat", 32'(sif.sched_pat), 32'(p));
      check("step_fg", 32'(sif.sched_ftr_grp), 32'(g));
      check("step_blk", 32'(sif.sched_blk), 32'(b));
      check("step_last", 32'(sif.sched_last), 32'(k == total - 1));
      check("step_layidx", 32'(layer_idx), 32'(lay));
      check("step_no_rstlay", 32'(rst_layer), 0);
      sif.sched_rdy = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      net_start = poke_start && (k == 1);
      @(posedge clk); #1;
      cyc++;
      net_start = 1'b0;
      if (sif.sched_rdy) k++;
    end
    check("step_count", 32'(k), 32'(total));
    sif.sched_rdy = 1'b0;
    check("done_rstlay", 32'(rst_layer), 1);
    check("done_netdone", 32'(net_done), 32'(is_last));
    check("done_no_val", 32'(sif.sched_val), 0);
    check("done_busy", 32'(busy), 1);
    cq_ptr++;
    present_cfg();
    @(posedge clk); #1;
    check("post_rstlay", 32'(rst_layer), 0);
    check("post_netdone", 32'(net_done), 0);
    check("post_busy", 32'(busy), 32'(!is_last));
    check("post_no_val", 32'(sif.sched_val), 0);
    if (!is_last) check("post_layidx", 32'(layer_idx), 32'(lay + 1));
  endtask

  initial begin
    cfg_t c;
    cfg_t c1;
    rst           = 1'b1;
    net_start     = 1'b0;
    sif.sched_rdy = 1'b0;
    sif.cfg_val   = 1'b0;
    scramble_cfg();
    repeat (3) @(posedge clk);
    #1;
    check_zero("reset");
    rst = 1'b0;
    @(posedge clk); #1;
    check("idle_busy", 32'(busy), 0);

    // Three fixed 2x2x2x2 layers: valid orders and an invalid one that falls back
    c1 = '{frm: 1, pat: 1, fg: 1, blk: 1, lay: 0, len: 5, dep: 9, pool: 3, pty: 6'b00_01_10};
    for (int t = 0; t < 3; t++) begin
      c = c1;
      if (t == 1) c.pty = 6'b10_01_00;
      if (t == 2) c.pty = 6'b11_00_00;
      c.len = c.len + t;
      cfgq.delete(); cq_ptr = 0;
      cfgq.push_back(c);
      present_cfg();
      start_net();
      run_layer(c, 0, 1'b1, 1'b0, 2, 1'b0, -1);
    end

    // Random shapes and orders under 50% backpressure
    for (int t = 0; t < 3; t++) begin
      c = rand_cfg();
      if (t == 2) c.pty = 6'($urandom);
      cfgq.delete(); cq_ptr = 0;
      cfgq.push_back(c);
      present_cfg();
      start_net();
      run_layer(c, 0, 1'b1, 1'b1, 2, 1'b0, -1);
    end

    // Three-layer network; only the first word's NumLay counts
    cfgq.delete(); cq_ptr = 0;
    for (int l = 0; l < 3; l++) begin
      c = rand_cfg();
      c.lay = (l == 0) ? 2 : (l == 1) ? 1 : 0;
      cfgq.push_back(c);
    end
    present_cfg();
    start_net();
    run_layer(cfgq[0], 0, 1'b0, 1'b1, 2, 1'b0, -1);
    run_layer(cfgq[1], 1, 1'b0, 1'b0, 3, 1'b1, -1);
    run_layer(cfgq[2], 2, 1'b1, 1'b1, 3, 1'b0, -1);

    // Reset on step 5, then a clean restart
    c = c1;
    cfgq.delete(); cq_ptr = 0;
    cfgq.push_back(c);
    present_cfg();
    start_net();
    run_layer(c, 0, 1'b1, 1'b0, 2, 1'b0, 4);
    rst = 1'b1;
    #1;
    check_zero("midrst");
    @(posedge clk); #1;
    check("midrst_edge_busy", 32'(busy), 0);
    check("midrst_edge_rstlay", 32'(rst_layer), 0);
    rst = 1'b0;
    sif.sched_rdy = 1'b0;
    present_cfg();
    @(posedge clk); #1;
    start_net();
    run_layer(c, 0, 1'b1, 1'b1, 2, 1'b0, -1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/cfg_sched.md
# cfg_sched

Layer loop scheduler. It sits directly downstream of the layer configuration FIFO stage and consumes that stage's decoded CFG_* fields. For each layer it walks the frame/patch/filter-group/block iteration space in the order given by the loop-priority field, and hands one step at a time to the compute array through a valid/ready handshake. It pulses Rst_Layer to pop the next layer's configuration and flags the end of the network after the configured number of layers.

## Interface
- LENROW_W, 4: width of CFG_LenRow
- BLK_W, 6: width of CFG_DepBlk and CFG_NumBlk
- FRAME_W, 5: width of CFG_NumFrm
- PATCH_W, 6: width of CFG_NumPat
- FTRGRP_W, 4: width of CFG_NumFtrGrp
- LAYER_W, 5: width of CFG_NumLay
- POOL_W, 4: width of CFG_POOL
- clk  in  1  single clock; all state changes on the rising edge
- Reset  in  1  asynchronous, active-high reset
- Net_Start  in  1  one-cycle pulse that starts a network run
- CFG_Val  in  1  the configuration FIFO output holds a valid layer word
- CFG_LoopPty  in  6  loop order: [5:4] outer, [3:2] middle, [1:0] inner; 0=patch, 1=ftrgrp, 2=blk
- CFG_LenRow, CFG_DepBlk, CFG_NumBlk, CFG_NumFrm, CFG_NumPat, CFG_NumFtrGrp, CFG_NumLay, CFG_POOL  in  per param  layer fields; each Num* encodes count-1
- Sched_Rdy  in  1  compute array accepts the current step
- Sched_Val  out  1  current step valid
- Sched_Frm / Sched_Pat / Sched_FtrGrp / Sched_Blk  out  FRAME_W/PATCH_W/FTRGRP_W/BLK_W  current loop indices
- Sched_Last  out  1  current step is the final step of the layer
- Sched_LenRow / Sched_DepBlk / Sched_POOL  out  per param  latched layer parameters
- Layer_Idx  out  LAYER_W  index of the current layer
- Rst_Layer  out  1  one-cycle pop to the configuration FIFO
- Net_Done  out  1  one-cycle pulse after the last layer completes
- Busy  out  1  high in every state except IDLE

## Operation
- States: IDLE, WAIT, LOAD, RUN, DONE, SETTLE.
- IDLE: Net_Start -> WAIT, and Layer_Idx is set to 0. Net_Start is ignored in every other state.
- WAIT: when CFG_Val=1 -> LOAD.
- LOAD (one cycle):
  - latch all CFG_* fields;
  - latch NumLay only when Layer_Idx=0;
  - zero all indices;
  - decode loop order -> RUN.
- Loop order decode: if the three 2-bit ids are not a permutation of {0,1,2}, use outer=patch, middle=ftrgrp, inner=blk.
- Frame loop: always outermost, outside the three ordered loops.
- RUN:
  - Sched_Val=1.
  - On Sched_Val&&Sched_Rdy the inner index increments. When it reaches its count-1 it wraps to 0 and carries to the middle index, then to the outer index, then to frame.
  - Sched_Last=1 when every index equals its count-1.
  - An accepted step with Sched_Last=1 -> DONE.
- DONE (one cycle): Rst_Layer=1 and Sched_Val=0.
  - If Layer_Idx == latched NumLay: Net_Done=1 -> IDLE.
  - Otherwise: Layer_Idx+1 -> SETTLE.
- SETTLE (one cycle): CFG_Val is ignored while the FIFO output updates -> WAIT.
- Index arithmetic: unsigned, each at its own width. Comparisons are against the latched count-1 fields, so a count of 1 (field=0) gives a single iteration of that loop.
- Total steps per layer = (NumFrm+1)(NumPat+1)(NumFtrGrp+1)(NumBlk+1).

## Timing
- Reset values:
  - state IDLE;
  - all outputs 0, including indices, Layer_Idx and latched parameters.
- Net_Start at cycle t -> WAIT at t+1.
- CFG_Val seen in WAIT at cycle t -> LOAD at t+1 -> first Sched_Val at t+2.
- Sched_Val, the indices and Sched_Last are registered and stay stable while Sched_Rdy=0. Sched_Val does not drop mid-layer.
- Throughput: one step per cycle while Sched_Rdy=1.
- Last step accepted at cycle t -> Rst_Layer at t+1 -> Net_Done also at t+1 if this was the last layer -> WAIT at t+3 otherwise.
- Reset asserted mid-run: immediate return to IDLE with all outputs 0. No Rst_Layer is issued. The FIFO contents are not touched by this block.
- CFG_* fields are sampled only in LOAD; changes on them during RUN have no effect.

## Test plan
- Single layer, NumFrm=1, NumPat=1, NumFtrGrp=1, NumBlk=1, LoopPty=6'b00_01_10, Sched_Rdy=1, NumLay=0 -> 16 consecutive steps with Blk toggling fastest, Sched_Last only on step 16, then one Rst_Layer pulse and Net_Done in the same cycle.
- Same layer with LoopPty=6'b10_01_00 -> Pat is the fastest index, Blk the slowest inside a frame; still 16 steps.
- LoopPty=6'b11_00_00 (invalid) -> order falls back to patch/ftrgrp/blk, giving the same sequence as the first test.
- Random Sched_Rdy backpressure at 50% -> indices held while Rdy=0, no step skipped or duplicated, count matches the product formula.
- NumLay=2 with three configs queued -> Layer_Idx 0,1,2; three Rst_Layer pulses; Net_Done only after the third; CFG_Val ignored in SETTLE.
- Reset asserted on step 5 of a layer -> all outputs 0 on the next edge; a subsequent Net_Start restarts from Layer_Idx=0.
